instr_enc: RTL and testbench

INSTR_ENC -- requirements
Module: instr_enc

---
 rtl/instr_enc.sv | 137 +++++++++++++
 tb/tb_instr_enc.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_enc.sv
// RV32I instruction encoder: packs a field bundle into a 32-bit word and queues it in a 2-entry output FIFO.
// Optional macro INSTR_ENC_RANGE_CHECK_EN flags immediates that do not fit their format.
module instr_enc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] enc_word;
    logic        enc_err;

    always_comb begin
        enc_word = 32'h0;
        enc_err  = 1'b0;
        case (opcode)
            OP_REG: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                enc_word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                enc_err  = (imm != {{20{imm[11]}}, imm[11:0]});
`endif
            end
            OP_STORE: begin
                enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                enc_err  = (imm != {{20{imm[11]}}, imm[11:0]});
`endif
            end
            OP_BRANCH: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                enc_err  = imm[0] || (imm != {{19{imm[12]}}, imm[12:0]});
`endif
            end
            OP_LUI, OP_AUIPC: begin
                enc_word = {imm[31:12], rd, opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                enc_err  = (imm[11:0] != 12'h0);
`endif
            end
            OP_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef INSTR_ENC_RANGE_CHECK_EN
                enc_err  = imm[0] || (imm != {{11{imm[20]}}, imm[20:0]});
`endif
            end
            default: begin
                enc_word = 32'h0;
                enc_err  = 1'b1;
            end
        endcase
    end

    // Each entry holds {err, word}.
    logic [32:0] mem_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        push, pop;
    logic [32:0] head;

    assign head      = mem_q[rd_ptr_q];
    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign instr     = out_valid ? head[31:0] : 32'h0;
    assign err       = out_valid ? head[32] : 1'b0;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (head[32] && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]  <= 33'h0;
            mem_q[1]  <= 33'h0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            err_cnt_q <= 8'h0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {enc_err, enc_word};
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed RV32I cases, backpressure, reset and a randomized run
// against a queue-based reference model.
module tb_instr_enc;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [7:0]  err_cnt;

    instr_enc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .err(err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef INSTR_ENC_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    int          exp_err_cnt = 0;

    logic        s_valid, s_ready, s_err;
    logic [31:0] s_instr;
    logic [7:0]  s_err_cnt;

    logic [6:0] legal_ops [9] = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder: format chosen by opcode, range judged on the signed immediate value.
    function automatic logic [32:0] model(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a,
                                          input logic [4:0] b, input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] im);
        longint s;
        logic [31:0] w;
        bit legal, bad;
        s = longint'($signed(im));
        legal = 1'b1;
        bad = 1'b0;
        w = 32'h0;
        case (o)
            7'b0110011: w = {f7, b, a, f3, d, o};
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w = {im[11:0], a, f3, d, o};
                bad = (s < -2048) || (s > 2047);
            end
            7'b0100011: begin
                w = {im[11:5], b, a, f3, im[4:0], o};
                bad = (s < -2048) || (s > 2047);
            end
            7'b1100011: begin
                w = {im[12], im[10:5], b, a, f3, im[4:1], im[11], o};
                bad = (s % 2 != 0) || (s < -4096) || (s > 4095);
            end
            7'b0110111, 7'b0010111: begin
                w = {im[31:12], d, o};
                bad = (im % 4096) != 0;
            end
            7'b1101111: begin
                w = {im[20], im[10:1], im[11], im[19:12], d, o};
                bad = (s % 2 != 0) || (s < -1048576) || (s > 1048575);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) return {1'b1, 32'h0};
        return {RANGE_CHECK && bad, w};
    endfunction

    // One cycle: sample and check at negedge, update the model for the coming edge.
    task automatic step();
        logic [32:0] w;
        bit acc, pop;
        @(negedge clk);
        s_valid = out_valid; s_ready = in_ready; s_err = err;
        s_instr = instr; s_err_cnt = err_cnt;
        check("in_ready", {31'h0, in_ready}, {31'h0, exp_q.size() < 2});
        check("out_valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("instr", instr, exp_q[0][31:0]);
            check("err", {31'h0, err}, {31'h0, exp_q[0][32]});
        end
        check("err_cnt", {24'h0, err_cnt}, exp_err_cnt);
        pop = out_ready && (exp_q.size() != 0);
        acc = in_valid && (exp_q.size() < 2);
        if (pop) begin
            w = exp_q.pop_front();
            if (w[32] && exp_err_cnt < 255) exp_err_cnt++;
        end
        if (acc) exp_q.push_back(model(opcode, rd, rs1, rs2, funct3, funct7, imm));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        opcode = o; rd = d; rs1 = a; rs2 = b; funct3 = f3; funct7 = f7; imm = im;
        in_valid = 1'b1;
    endtask

    // Send one bundle with out_ready high; afterwards s_* holds the word seen one cycle later.
    task automatic one_word(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        out_ready = 1'b1;
        drive(o, d, a, b, f3, f7, im);
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic rand_bundle();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) == 0) opcode = 7'($urandom);
        else opcode = legal_ops[$urandom_range(0, 8)];
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        case ($urandom_range(0, 5))
            0: imm = {{20{r[11]}}, r[11:0]};
            1: imm = {{19{r[12]}}, r[12:1], 1'b0};
            2: imm = {{11{r[20]}}, r[20:1], 1'b0};
            3: imm = {r[31:12], 12'h0};
            4: imm = 32'(int'($urandom_range(0, 8)) - 4);
            default: imm = r;
        endcase
        in_valid = ($urandom_range(0, 9) < 7);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = 7'h0; rd = 5'h0; rs1 = 5'h0; rs2 = 5'h0;
        funct3 = 3'h0; funct7 = 7'h0; imm = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_instr", instr, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        one_word(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        check("addi_valid", {31'h0, s_valid}, 32'h1);
        check("addi_instr", s_instr, 32'h00500093);
        check("addi_err", {31'h0, s_err}, 32'h0);

        one_word(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC);
        check("beq_instr", s_instr, 32'hFE000EE3);
        check("beq_err", {31'h0, s_err}, 32'h0);

        one_word(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        check("jal_instr", s_instr, 32'h008000EF);
        check("jal_err", {31'h0, s_err}, 32'h0);

        one_word(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        check("range_instr", s_instr, 32'h80000093);
        check("range_err", {31'h0, s_err}, {31'h0, RANGE_CHECK});
        step();
        check("range_err_cnt", {24'h0, s_err_cnt}, {31'h0, RANGE_CHECK});

        one_word(7'b1111111, 5'd3, 5'd4, 5'd5, 3'd7, 7'h55, 32'h1234);
        check("illegal_instr", s_instr, 32'h0);
        check("illegal_err", {31'h0, s_err}, 32'h1);

        out_ready = 1'b0;
        drive(7'b0110011, 5'd2, 5'd3, 5'd4, 3'd0, 7'h20, 32'h0);
        step();
        drive(7'b0100011, 5'd0, 5'd6, 5'd7, 3'd2, 7'h0, 32'h10);
        step();
        drive(7'b0110111, 5'd9, 5'd0, 5'd0, 3'd0, 7'h0, 32'hABCDE000);
        step();
        check("bp_in_ready_low", {31'h0, s_ready}, 32'h0);
        step();
        check("bp_held_ready", {31'h0, s_ready}, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        check("bp_ready_back", {31'h0, s_ready}, 32'h1);
        in_valid = 1'b0;
        step();
        check("bp_third_word", s_instr, 32'hABCDE4B7);
        step();

        for (int i = 0; i < 600; i++) begin
            rand_bundle();
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        drive(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0);
        repeat (262) step();
        in_valid = 1'b0;
        repeat (3) step();
        check("err_cnt_sat", {24'h0, s_err_cnt}, 32'hFF);

        out_ready = 1'b0;
        drive(7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        drive(7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2);
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", {31'h0, s_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        check("midrst_instr", instr, 32'h0);
        exp_q.delete();
        exp_err_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) step();
        check("post_rst_empty", {31'h0, s_valid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
